// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage.
package ifetch_pkg;
    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} fetch_state_t;
    typedef logic [1:0] byte_idx_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_word_t;
endpackage

// File: rtl/ifetch_word_asm.sv
// Byte-lane assembly of one 32-bit word from four byte reads; tracks the
// byte counter and the single in-flight byte, pulses done on byte 3 data.
module ifetch_word_asm
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic        grant,
    input  logic [7:0]  din,
    output byte_idx_t   k,
    output logic        done,
    output logic [31:0] word_now,
    output logic [31:0] word_held
);
    logic [3:0][7:0] lanes;
    logic            pend_vld;
    byte_idx_t       pend_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            pend_vld <= 1'b0;
            pend_idx <= '0;
        end else if (flush) begin
            k        <= '0;
            pend_vld <= 1'b0;
        end else if (en) begin
            pend_vld <= grant;
            if (grant) begin
                pend_idx <= k;
                k        <= k + 2'd1;
            end
        end
    end

    // Data for a granted byte shows up one active cycle later; flush drops it.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                lanes[i] <= '0;
            else if (en && !flush && pend_vld && pend_idx == byte_idx_t'(i))
                lanes[i] <= din;
        end
    end

    assign done      = en && !flush && pend_vld && (pend_idx == 2'd3);
    assign word_now  = {din, lanes[2], lanes[1], lanes[0]};
    assign word_held = lanes;
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: byte-serial reads through the arbiter, word assembly,
// push into the instruction queue. Optional IFETCH_SKID_EN adds a skid entry.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    input  logic        queue_full,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
);
    fetch_state_t state, state_nxt;
    logic         active;
    logic [31:0]  pc;
    byte_idx_t    k;
    logic         done;
    logic [31:0]  word_now, word_held;
    logic         grant, push, out_free, blocked;
    logic [31:0]  word_pc;
    fetch_word_t  out_r;

    // pc has already advanced past the word that is completing or held.
    assign word_pc  = pc - 32'd4;
    assign push     = rdy_in && instr_valid && !queue_full && !redirect;
    assign out_free = !instr_valid || push;
    assign grant    = rdy_in && mem_rd && mem_grant && !redirect;

`ifdef IFETCH_SKID_EN
    fetch_word_t skid_r;
    logic        skid_vld;
    assign blocked = instr_valid && skid_vld;
`else
    assign blocked = instr_valid;
`endif

    ifetch_word_asm u_asm (
        .clk       (clk_in),
        .rst       (rst_in),
        .en        (rdy_in),
        .flush     (redirect),
        .grant     (grant),
        .din       (mem_din),
        .k         (k),
        .done      (done),
        .word_now  (word_now),
        .word_held (word_held)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect)
            state_nxt = FETCH;
        else if (rdy_in) begin
`ifdef IFETCH_SKID_EN
            if (state == FETCH && done && !out_free && skid_vld) state_nxt = HOLD;
            else if (state == HOLD && push)                      state_nxt = FETCH;
`else
            if (state == FETCH && done && !out_free)   state_nxt = HOLD;
            else if (state == HOLD && !instr_valid)    state_nxt = FETCH;
`endif
        end
    end

    // A new word is not started while there is nowhere for it to go.
    always_comb begin
        mem_rd   = active && (state == FETCH) && !(blocked && k == 2'd0);
        mem_addr = mem_rd ? pc + {30'd0, k} : 32'd0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            active      <= 1'b0;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            out_r       <= '0;
`ifdef IFETCH_SKID_EN
            skid_vld    <= 1'b0;
            skid_r      <= '0;
`endif
        end else begin
            active <= 1'b1;
            if (redirect) begin
                pc          <= redirect_pc;
                instr_valid <= 1'b0;
`ifdef IFETCH_SKID_EN
                skid_vld    <= 1'b0;
`endif
            end else if (rdy_in) begin
                if (grant && k == 2'd3)
                    pc <= pc + 32'd4;
`ifdef IFETCH_SKID_EN
                if (state == HOLD) begin
                    if (push) begin
                        out_r  <= skid_r;
                        skid_r <= '{pc: word_pc, word: word_held};
                    end
                end else if (done) begin
                    if (out_free) begin
                        instr_valid <= 1'b1;
                        if (skid_vld) begin
                            out_r  <= skid_r;
                            skid_r <= '{pc: word_pc, word: word_now};
                        end else
                            out_r  <= '{pc: word_pc, word: word_now};
                    end else if (!skid_vld) begin
                        skid_r   <= '{pc: word_pc, word: word_now};
                        skid_vld <= 1'b1;
                    end
                end else if (push) begin
                    if (skid_vld) begin
                        out_r    <= skid_r;
                        skid_vld <= 1'b0;
                    end else
                        instr_valid <= 1'b0;
                end
`else
                // Held word reloads only once the output has gone empty.
                if (state == HOLD && !instr_valid) begin
                    out_r       <= '{pc: word_pc, word: word_held};
                    instr_valid <= 1'b1;
                end else if (state == FETCH && done && out_free) begin
                    out_r       <= '{pc: word_pc, word: word_now};
                    instr_valid <= 1'b1;
                end else if (push)
                    instr_valid <= 1'b0;
`endif
            end
        end
    end

    assign instr_out = out_r.word;
    assign instr_pc  = out_r.pc;
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a byte-memory model and a queue of
// expected pushes; valid for builds with or without IFETCH_SKID_EN.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_din = 8'h00;
    logic        queue_full;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    int          errors = 0;
    int          checks = 0;
    logic        force_full = 1'b0;
    fetch_word_t exp_q[$];

    ifetch_unit dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_grant   (mem_grant),
        .mem_din     (mem_din),
        .queue_full  (queue_full),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] mb(input logic [31:0] a);
        logic [7:0] t;
        case (a)
            32'd0:   t = 8'h13;
            32'd1:   t = 8'h05;
            32'd2:   t = 8'h00;
            32'd3:   t = 8'h00;
            default: t = (a[7:0] * 8'd7) ^ 8'h5A ^ a[31:24];
        endcase
        return t;
    endfunction

    function automatic logic [31:0] wd(input logic [31:0] p);
        return {mb(p + 32'd3), mb(p + 32'd2), mb(p + 32'd1), mb(p)};
    endfunction

    always @(posedge clk_in)
        if (rdy_in && mem_rd && mem_grant) mem_din <= mb(mem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] p);
        exp_q.push_back('{pc: p, word: wd(p)});
    endtask

    // One cycle: drive queue_full, score any push, advance to the next negedge.
    task automatic step();
        fetch_word_t e;
        queue_full = force_full || (exp_q.size() == 0);
        if (instr_valid && !queue_full && rdy_in && !redirect) begin
            e = exp_q.pop_front();
            chk("push_pc", {32'd0, instr_pc}, {32'd0, e.pc});
            chk("push_word", {32'd0, instr_out}, {32'd0, e.word});
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drain(input string tag, input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_redirect(input logic [31:0] p);
        redirect    = 1'b1;
        redirect_pc = p;
        expect_word(p);
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        int n;
        rst_in = 1'b1; rdy_in = 1'b1; redirect = 1'b0; redirect_pc = '0;
        mem_grant = 1'b1; queue_full = 1'b1;
        repeat (3) @(negedge clk_in);

        chk("rst_mem_rd", {63'd0, mem_rd}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr_out", {32'd0, instr_out}, 64'd0);
        chk("rst_instr_pc", {32'd0, instr_pc}, 64'd0);

        // First word after reset: addresses in cycles 1-4, valid in cycle 6.
        expect_word(32'h0);
        rst_in = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("boot_addr", {31'd0, mem_rd, mem_addr}, {31'd0, 1'b1, 32'(i)});
            step();
        end
        chk("boot_valid_c5", {63'd0, instr_valid}, 64'd0);
        step();
        chk("boot_valid_c6", {31'd0, instr_valid, instr_out}, {31'd0, 1'b1, 32'h0000_0513});
        step();

        // Back-pressure: output must hold steady, then drain in order.
        force_full = 1'b1;
        n = 0;
        while (!instr_valid && n < 20) begin step(); n++; end
        chk("hold_first_valid", {63'd0, instr_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_out", {31'd0, instr_valid, instr_out}, {31'd0, 1'b1, wd(32'h4)});
            chk("hold_pc", {32'd0, instr_pc}, 64'h4);
            step();
        end
        chk("hold_no_issue", {63'd0, mem_rd}, 64'd0);
        expect_word(32'h4); expect_word(32'h8); expect_word(32'hC);
        force_full = 1'b0;
        drain("hold_drain", 60);

        // Redirect to 0x8, then to 0x100 while byte 2 of 0x8 data returns.
        exp_q.delete();
        redirect = 1'b1; redirect_pc = 32'h8;
        step();
        redirect = 1'b0;
        chk("redir8_addr", {31'd0, mem_rd, mem_addr}, {31'd0, 1'b1, 32'h8});
        step(); step(); step();
        do_redirect(32'h100);
        chk("redir_addr", {31'd0, mem_rd, mem_addr}, {31'd0, 1'b1, 32'h100});
        repeat (4) step();
        chk("redir_valid_t5", {63'd0, instr_valid}, 64'd0);
        step();
        chk("redir_valid_t6", {63'd0, instr_valid}, 64'd1);
        step();
        chk("redir_drain", 64'(exp_q.size()), 64'd0);

        // Grant withheld 3 cycles on byte 2.
        do_redirect(32'h20);
        chk("gap_addr0", {31'd0, mem_rd, mem_addr}, {31'd0, 1'b1, 32'h20});
        step(); step();
        mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("gap_addr_hold", {31'd0, mem_rd, mem_addr}, {31'd0, 1'b1, 32'h22});
            step();
        end
        mem_grant = 1'b1;
        step(); step();
        chk("gap_valid_t8", {63'd0, instr_valid}, 64'd0);
        step();
        chk("gap_valid_t9", {63'd0, instr_valid}, 64'd1);
        step();
        chk("gap_drain", 64'(exp_q.size()), 64'd0);

        // rdy_in low 5 cycles mid-word.
        do_redirect(32'h40);
        chk("rdy_addr0", {31'd0, mem_rd, mem_addr}, {31'd0, 1'b1, 32'h40});
        step(); step();
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rdy_frozen", {30'd0, instr_valid, mem_rd, mem_addr}, {30'd0, 1'b0, 1'b1, 32'h42});
            step();
        end
        rdy_in = 1'b1;
        step(); step();
        chk("rdy_valid_t10", {63'd0, instr_valid}, 64'd0);
        step();
        chk("rdy_valid_t11", {63'd0, instr_valid}, 64'd1);
        step();
        chk("rdy_drain", 64'(exp_q.size()), 64'd0);

        // Address wrap at the top of the 32-bit space.
        do_redirect(32'hFFFF_FFFC);
        expect_word(32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", {31'd0, mem_rd, mem_addr}, {31'd0, 1'b1, 32'hFFFF_FFFC + 32'(i)});
            step();
        end
        chk("wrap_next", {31'd0, mem_rd, mem_addr}, {31'd0, 1'b1, 32'h0});
        drain("wrap_drain", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
